// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu multiply/popcount initiator: slave register map,
// status encoding, FSM state and bus phase enums.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_RES  = 16'h0390;
    localparam logic [15:0] ADDR_CNT  = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam logic [1:0]  STAT_DONE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_A1     = 4'd1,
        ST_WR_A2     = 4'd2,
        ST_WR_GO     = 4'd3,
        ST_POLL      = 4'd4,
        ST_POLL_WAIT = 4'd5,
        ST_RD_RES    = 4'd6,
        ST_RD_CNT    = 4'd7,
        ST_RESP      = 4'd8
    } init_state_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_HOLD   = 2'd3
    } bus_phase_e;

    // Operands are 24 bits wide; the upper data byte on the bus is always zero.
    function automatic logic [31:0] pad_operand(input logic [23:0] op);
        return {8'h00, op};
    endfunction

endpackage

// File: rtl/gpioemu_bus_xact.sv
// Single strobe-bus transaction engine: SETUP (1 cycle), STROBE (STROBE_CYCLES cycles),
// HOLD (1 cycle). All bus outputs are registered; done is high during the HOLD cycle.
module gpioemu_bus_xact
    import gpioemu_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);

    bus_phase_e  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rnw_q, rnw_d;
    logic [15:0] saddress_q, saddress_d;
    logic        srd_q, srd_d;
    logic        swr_q, swr_d;
    logic [31:0] sdata_out_q, sdata_out_d;
    logic [31:0] rdata_q, rdata_d;

    // Phase sequencing; read data is captured on the edge that leaves the strobe window.
    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        rnw_d       = rnw_q;
        saddress_d  = saddress_q;
        srd_d       = srd_q;
        swr_d       = swr_q;
        sdata_out_d = sdata_out_q;
        rdata_d     = rdata_q;
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d     = PH_SETUP;
                    rnw_d       = rnw;
                    saddress_d  = addr;
                    sdata_out_d = rnw ? 32'h0000_0000 : wdata;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_SETUP: begin
                phase_d = PH_STROBE;
                cnt_d   = STROBE_LAST;
                srd_d   = rnw_q;
                swr_d   = ~rnw_q;
            end
            PH_STROBE: begin
                if (cnt_q == 8'd0) begin
                    phase_d = PH_HOLD;
                    srd_d   = 1'b0;
                    swr_d   = 1'b0;
                    if (rnw_q) begin
                        rdata_d = sdata_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PH_HOLD: begin
                phase_d = PH_IDLE;
            end
            default: begin
                phase_d = PH_IDLE;
                srd_d   = 1'b0;
                swr_d   = 1'b0;
            end
        endcase
    end

    // Bus state registers; async reset drops the strobes immediately.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q     <= PH_IDLE;
            cnt_q       <= 8'd0;
            rnw_q       <= 1'b0;
            saddress_q  <= 16'h0000;
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            sdata_out_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
        end else begin
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            rnw_q       <= rnw_d;
            saddress_q  <= saddress_d;
            srd_q       <= srd_d;
            swr_q       <= swr_d;
            sdata_out_q <= sdata_out_d;
            rdata_q     <= rdata_d;
        end
    end

    assign busy      = (phase_q != PH_IDLE);
    assign done      = (phase_q == PH_HOLD);
    assign rdata     = rdata_q;
    assign saddress  = saddress_q;
    assign srd       = srd_q;
    assign swr       = swr_q;
    assign sdata_out = sdata_out_q;

endmodule

// File: rtl/gpioemu_mult_initiator.sv
// Job-level initiator for the gpioemu multiply/popcount slave: loads operands, starts the
// slave, polls status with a bounded retry count, reads result and ones count, responds.
module gpioemu_mult_initiator
    import gpioemu_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned MAX_POLLS     = 64
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_a1,
    input  logic [23:0] req_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [5:0]  rsp_ones,
    output logic        rsp_err,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic [15:0] jobs_done
);

    localparam logic [15:0] MAX_POLLS_W = 16'(MAX_POLLS);
    localparam logic [15:0] GAP_LAST    = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

    init_state_e state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [23:0] a1_q, a1_d;
    logic [23:0] a2_q, a2_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] gap_q, gap_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [5:0]  rsp_ones_q, rsp_ones_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] jobs_done_q, jobs_done_d;

    logic        x_start_s;
    logic        x_rnw_s;
    logic [15:0] x_addr_s;
    logic [31:0] x_wdata_s;
    logic        x_busy_s;
    logic        x_done_s;
    logic [31:0] x_rdata_s;
    logic [15:0] poll_next_s;

    gpioemu_bus_xact #(
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_xact (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (x_start_s),
        .rnw       (x_rnw_s),
        .addr      (x_addr_s),
        .wdata     (x_wdata_s),
        .busy      (x_busy_s),
        .done      (x_done_s),
        .rdata     (x_rdata_s),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    assign poll_next_s = poll_cnt_q + 16'd1;

    // Job FSM: each bus state launches one transaction and advances on its HOLD cycle.
    always_comb begin
        state_d      = state_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        poll_cnt_d   = poll_cnt_q;
        gap_d        = gap_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_ones_d   = rsp_ones_q;
        rsp_err_d    = rsp_err_q;
        jobs_done_d  = jobs_done_q;
        x_start_s    = 1'b0;
        x_rnw_s      = 1'b0;
        x_addr_s     = 16'h0000;
        x_wdata_s    = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a1_d         = req_a1;
                    a2_d         = req_a2;
                    poll_cnt_d   = 16'd0;
                    rsp_result_d = 32'h0000_0000;
                    rsp_ones_d   = 6'd0;
                    rsp_err_d    = 1'b0;
                    state_d      = ST_WR_A1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A1: begin
                x_start_s = ~x_busy_s;
                x_addr_s  = ADDR_A1;
                x_wdata_s = pad_operand(a1_q);
                state_d   = x_done_s ? ST_WR_A2 : ST_WR_A1;
            end
            ST_WR_A2: begin
                x_start_s = ~x_busy_s;
                x_addr_s  = ADDR_A2;
                x_wdata_s = pad_operand(a2_q);
                state_d   = x_done_s ? ST_WR_GO : ST_WR_A2;
            end
            ST_WR_GO: begin
                x_start_s = ~x_busy_s;
                x_addr_s  = ADDR_CTRL;
                x_wdata_s = 32'h0000_0000;
                state_d   = x_done_s ? ST_POLL : ST_WR_GO;
            end
            ST_POLL: begin
                x_start_s = ~x_busy_s;
                x_rnw_s   = 1'b1;
                x_addr_s  = ADDR_CTRL;
                if (x_done_s) begin
                    poll_cnt_d = poll_next_s;
                    if (x_rdata_s[1:0] == STAT_DONE) begin
                        state_d = ST_RD_RES;
                    end else if (poll_next_s >= MAX_POLLS_W) begin
                        // Timeout: respond with an error and zeroed payload.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = 32'h0000_0000;
                        rsp_ones_d   = 6'd0;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        gap_d   = GAP_LAST;
                        state_d = ST_POLL_WAIT;
                    end
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL_WAIT: begin
                if (gap_q == 16'd0) begin
                    state_d = ST_POLL;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            ST_RD_RES: begin
                x_start_s = ~x_busy_s;
                x_rnw_s   = 1'b1;
                x_addr_s  = ADDR_RES;
                if (x_done_s) begin
                    rsp_result_d = x_rdata_s;
                    state_d      = ST_RD_CNT;
                end else begin
                    state_d = ST_RD_RES;
                end
            end
            ST_RD_CNT: begin
                x_start_s = ~x_busy_s;
                x_rnw_s   = 1'b1;
                x_addr_s  = ADDR_CNT;
                if (x_done_s) begin
                    rsp_ones_d  = x_rdata_s[5:0];
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_RD_CNT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        // Ready follows the next state, so it rises one cycle after reset release.
        req_ready_d = (state_d == ST_IDLE);
    end

    // Job and response registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            a1_q         <= 24'h0;
            a2_q         <= 24'h0;
            poll_cnt_q   <= 16'd0;
            gap_q        <= 16'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'h0000_0000;
            rsp_ones_q   <= 6'd0;
            rsp_err_q    <= 1'b0;
            jobs_done_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_q        <= gap_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ones_q   <= rsp_ones_d;
            rsp_err_q    <= rsp_err_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ones   = rsp_ones_q;
    assign rsp_err    = rsp_err_q;
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_gpioemu_mult_initiator.sv
// Bench for gpioemu_mult_initiator: three instances (STROBE_CYCLES 1/2/3) run the same jobs
// in lockstep against a behavioural slave with exact 24x24 product and settable done delay.
module tb_gpioemu_mult_initiator;
    import gpioemu_pkg::*;

    localparam int NI   = 3;
    localparam int MAXP = 4;

    typedef struct packed {
        logic        rnw;
        logic [15:0] addr;
        logic [31:0] data;
    } xact_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [23:0] req_a1 = 24'h0;
    logic [23:0] req_a2 = 24'h0;

    logic        req_ready_w  [NI];
    logic        rsp_valid_w  [NI];
    logic [31:0] rsp_result_w [NI];
    logic [5:0]  rsp_ones_w   [NI];
    logic        rsp_err_w    [NI];
    logic [15:0] saddress_w   [NI];
    logic        srd_w        [NI];
    logic        swr_w        [NI];
    logic [31:0] sdata_out_w  [NI];
    logic [31:0] sdata_in_w   [NI];
    logic [15:0] jobs_done_w  [NI];

    logic [23:0] sl_a1      [NI];
    logic [23:0] sl_a2      [NI];
    int          sl_cnt     [NI];
    logic        sl_started [NI];
    logic        sl_never   [NI];
    int          slave_delay = 0;

    xact_t       log_q     [NI][$];
    logic        prev_st   [NI];
    logic [15:0] prev_addr [NI];
    int          width     [NI];

    int checks = 0;
    int errors = 0;
    int jobs_model = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            gpioemu_mult_initiator #(
                .STROBE_CYCLES (gi + 1),
                .POLL_GAP      (4),
                .MAX_POLLS     (MAXP)
            ) u_dut (
                .clk        (clk),
                .n_reset    (n_reset),
                .req_valid  (req_valid),
                .req_ready  (req_ready_w[gi]),
                .req_a1     (req_a1),
                .req_a2     (req_a2),
                .rsp_valid  (rsp_valid_w[gi]),
                .rsp_ready  (rsp_ready),
                .rsp_result (rsp_result_w[gi]),
                .rsp_ones   (rsp_ones_w[gi]),
                .rsp_err    (rsp_err_w[gi]),
                .saddress   (saddress_w[gi]),
                .srd        (srd_w[gi]),
                .swr        (swr_w[gi]),
                .sdata_out  (sdata_out_w[gi]),
                .sdata_in   (sdata_in_w[gi]),
                .jobs_done  (jobs_done_w[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] prod_lo(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = 48'(a) * 48'(b);
        return p[31:0];
    endfunction

    function automatic logic [5:0] ones32(input logic [31:0] v);
        return 6'($countones(v));
    endfunction

    // Slave read data; upper bits carry junk so the initiator must mask them.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            case (saddress_w[i])
                ADDR_CTRL: sdata_in_w[i] = (sl_started[i] && !sl_never[i] && sl_cnt[i] == 0)
                                           ? 32'hA5A5_A5A7 : 32'hA5A5_A5A5;
                ADDR_RES:  sdata_in_w[i] = prod_lo(sl_a1[i], sl_a2[i]);
                ADDR_CNT:  sdata_in_w[i] = {26'h2AAAAAA, ones32(prod_lo(sl_a1[i], sl_a2[i]))};
                default:   sdata_in_w[i] = 32'hDEAD_BEEF;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        for (int i = 0; i < NI; i++) begin
            prev_st[i]    = 1'b0;
            prev_addr[i]  = 16'h0;
            width[i]      = 0;
            sl_started[i] = 1'b0;
            sl_never[i]   = 1'b0;
            sl_cnt[i]     = 0;
            sl_a1[i]      = 24'h0;
            sl_a2[i]      = 24'h0;
            log_q[i].delete();
        end
    endtask

    // One clock: advance the slave, record transactions, check strobe shape.
    task automatic step();
        logic st;
        @(posedge clk);
        #1;
        if (n_reset) begin
            for (int i = 0; i < NI; i++) begin
                if (sl_started[i] && sl_cnt[i] > 0) sl_cnt[i]--;
                chk($sformatf("no_overlap[%0d]", i), 64'(srd_w[i] & swr_w[i]), 64'd0);
                st = srd_w[i] | swr_w[i];
                if (st && !prev_st[i]) begin
                    chk($sformatf("setup_addr[%0d]", i), 64'(saddress_w[i]), 64'(prev_addr[i]));
                    width[i] = 1;
                    log_q[i].push_back({srd_w[i], saddress_w[i], sdata_out_w[i]});
                    if (swr_w[i]) begin
                        if (saddress_w[i] == ADDR_A1) sl_a1[i] = sdata_out_w[i][23:0];
                        if (saddress_w[i] == ADDR_A2) sl_a2[i] = sdata_out_w[i][23:0];
                        if (saddress_w[i] == ADDR_CTRL) begin
                            sl_started[i] = 1'b1;
                            sl_never[i]   = (slave_delay < 0);
                            sl_cnt[i]     = (slave_delay < 0) ? 0 : slave_delay;
                        end
                    end
                end else if (st && prev_st[i]) begin
                    width[i]++;
                    chk($sformatf("strobe_addr[%0d]", i), 64'(saddress_w[i]), 64'(prev_addr[i]));
                end else if (!st && prev_st[i]) begin
                    chk($sformatf("strobe_width[%0d]", i), 64'(width[i]), 64'(i + 1));
                    chk($sformatf("hold_addr[%0d]", i), 64'(saddress_w[i]), 64'(prev_addr[i]));
                end
                prev_st[i]   = st;
                prev_addr[i] = saddress_w[i];
            end
        end
    endtask

    function automatic logic all_valid();
        logic v = 1'b1;
        for (int i = 0; i < NI; i++) v &= rsp_valid_w[i];
        return v;
    endfunction

    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, input int delay,
                           input int stall);
        logic        exp_err;
        logic [31:0] exp_res;
        logic [5:0]  exp_ones;
        int          n;
        xact_t       e;
        slave_delay = delay;
        exp_err  = (delay < 0);
        exp_res  = exp_err ? 32'h0 : prod_lo(a1, a2);
        exp_ones = exp_err ? 6'd0 : ones32(exp_res);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("req_ready_idle[%0d]", i), 64'(req_ready_w[i]), 64'd1);
            log_q[i].delete();
        end
        req_a1 = a1;
        req_a2 = a2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_a1 = 24'($urandom);
        req_a2 = 24'($urandom);
        for (int i = 0; i < NI; i++)
            chk($sformatf("req_ready_busy[%0d]", i), 64'(req_ready_w[i]), 64'd0);
        n = 0;
        while (!all_valid() && n < 3000) begin
            step();
            n++;
        end
        chk("rsp_valid_timeout", 64'(all_valid()), 64'd1);
        for (int k = 0; k < stall; k++) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("stall_valid[%0d]", i), 64'(rsp_valid_w[i]), 64'd1);
                chk($sformatf("stall_result[%0d]", i), 64'(rsp_result_w[i]), 64'(exp_res));
                chk($sformatf("stall_ones[%0d]", i), 64'(rsp_ones_w[i]), 64'(exp_ones));
                chk($sformatf("stall_ready[%0d]", i), 64'(req_ready_w[i]), 64'd0);
                chk($sformatf("stall_bus[%0d]", i), 64'(srd_w[i] | swr_w[i]), 64'd0);
                chk($sformatf("stall_jobs[%0d]", i), 64'(jobs_done_w[i]), 64'(16'(jobs_model)));
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rsp_result[%0d]", i), 64'(rsp_result_w[i]), 64'(exp_res));
            chk($sformatf("rsp_ones[%0d]", i), 64'(rsp_ones_w[i]), 64'(exp_ones));
            chk($sformatf("rsp_err[%0d]", i), 64'(rsp_err_w[i]), 64'(exp_err));
            n = log_q[i].size();
            if (exp_err) chk($sformatf("xact_count_err[%0d]", i), 64'(n), 64'(3 + MAXP));
            else chk($sformatf("xact_count_ok[%0d]", i), 64'((n >= 6) && (n <= 5 + MAXP)), 64'd1);
            for (int j = 0; j < n; j++) begin
                if (j == 0)                       e = {1'b0, ADDR_A1, 8'h00, a1};
                else if (j == 1)                  e = {1'b0, ADDR_A2, 8'h00, a2};
                else if (j == 2)                  e = {1'b0, ADDR_CTRL, 32'h0};
                else if (!exp_err && j == n - 2)  e = {1'b1, ADDR_RES, 32'h0};
                else if (!exp_err && j == n - 1)  e = {1'b1, ADDR_CNT, 32'h0};
                else                              e = {1'b1, ADDR_CTRL, 32'h0};
                chk($sformatf("xact_kind[%0d][%0d]", i, j), 64'({log_q[i][j].rnw, log_q[i][j].addr}),
                    64'({e.rnw, e.addr}));
                if (!e.rnw)
                    chk($sformatf("xact_wdata[%0d][%0d]", i, j), 64'(log_q[i][j].data), 64'(e.data));
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        jobs_model++;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rsp_valid_drop[%0d]", i), 64'(rsp_valid_w[i]), 64'd0);
            chk($sformatf("jobs_done[%0d]", i), 64'(jobs_done_w[i]), 64'(16'(jobs_model)));
        end
    endtask

    initial begin
        int n;
        clear_monitor();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_srd[%0d]", i), 64'(srd_w[i]), 64'd0);
            chk($sformatf("rst_swr[%0d]", i), 64'(swr_w[i]), 64'd0);
            chk($sformatf("rst_saddr[%0d]", i), 64'(saddress_w[i]), 64'd0);
            chk($sformatf("rst_sdata[%0d]", i), 64'(sdata_out_w[i]), 64'd0);
            chk($sformatf("rst_rsp[%0d]", i), 64'({rsp_valid_w[i], rsp_result_w[i], rsp_ones_w[i], rsp_err_w[i]}), 64'd0);
            chk($sformatf("rst_jobs[%0d]", i), 64'(jobs_done_w[i]), 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("ready_before_clk[%0d]", i), 64'(req_ready_w[i]), 64'd0);
        step();

        run_job(24'd3, 24'd5, 10, 0);
        run_job(24'hFFFFFF, 24'hFFFFFF, int'($urandom_range(0, 10)), 0);
        run_job(24'($urandom), 24'($urandom), -1, 0);
        run_job(24'($urandom), 24'($urandom), 5, 20);

        // Reset in the middle of the A2 write strobe.
        slave_delay = 3;
        req_a1 = 24'($urandom);
        req_a2 = 24'($urandom);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!(swr_w[1] && saddress_w[1] == ADDR_A2) && n < 200) begin
            step();
            n++;
        end
        chk("reach_wr_a2", 64'(swr_w[1] && saddress_w[1] == ADDR_A2), 64'd1);
        #2;
        n_reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mid_rst_swr[%0d]", i), 64'(swr_w[i]), 64'd0);
            chk($sformatf("mid_rst_srd[%0d]", i), 64'(srd_w[i]), 64'd0);
            chk($sformatf("mid_rst_valid[%0d]", i), 64'(rsp_valid_w[i]), 64'd0);
            chk($sformatf("mid_rst_ready[%0d]", i), 64'(req_ready_w[i]), 64'd0);
            chk($sformatf("mid_rst_jobs[%0d]", i), 64'(jobs_done_w[i]), 64'd0);
        end
        clear_monitor();
        jobs_model = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            for (int i = 0; i < NI; i++)
                chk($sformatf("post_rst_idle[%0d]", i), 64'({rsp_valid_w[i], srd_w[i], swr_w[i]}), 64'd0);
        end

        run_job(24'($urandom), 24'($urandom), 4, 0);
        for (int r = 0; r < 8; r++) begin
            run_job(24'($urandom), 24'($urandom),
                    ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 12)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
